// File: rtl/valid_dirty_ram.sv
// Per-way valid/dirty status array for the set-associative data cache, with a
// flush engine that invalidates every entry or hands dirty ones to write-back first.
module valid_dirty_ram #(
    parameter  int INDEX_W = 5,
    localparam int WAY_W   = 1,
    localparam int WAYS    = 2**WAY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic               w_en,
    input  logic [WAYS-1:0]    way_sel,
    input  logic               valid_in,
    input  logic               dirty_in,
    output logic [WAYS-1:0]    valid_out,
    output logic [WAYS-1:0]    dirty_out,
    input  logic               flush_req,
    input  logic               flush_wb,
    output logic               flush_busy,
    output logic               flush_done,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [INDEX_W-1:0] wb_index,
    output logic [WAY_W-1:0]   wb_way
);

    localparam int SETS  = 2**INDEX_W;
    localparam int CNT_W = INDEX_W + WAY_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SCAN    = 2'd1;
    localparam logic [1:0] WB_WAIT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]         state;
    logic [1:0]         nextState;
    logic [CNT_W-1:0]   scanCnt;
    logic               flushMode;

    logic [WAYS-1:0]    validMem [SETS];
    logic [WAYS-1:0]    dirtyMem [SETS];

    logic [INDEX_W-1:0] scanSet;
    logic [WAY_W-1:0]   scanWay;
    logic               scanLast;
    logic               holdForWb;
    logic               clearEntry;
    logic               writeEn;

    // Scan counter is {set, way} so the way index advances fastest.
    assign scanSet  = scanCnt[CNT_W-1:WAY_W];
    assign scanWay  = scanCnt[WAY_W-1:0];
    assign scanLast = (scanCnt == '1);

    assign holdForWb  = flushMode & validMem[scanSet][scanWay] & dirtyMem[scanSet][scanWay];
    assign clearEntry = ((state == SCAN) && !holdForWb) || ((state == WB_WAIT) && wb_ready);
    assign writeEn    = (state == IDLE) && w_en;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (flush_req) nextState = SCAN;
            SCAN: begin
                if (holdForWb)     nextState = WB_WAIT;
                else if (scanLast) nextState = DONE;
            end
            WB_WAIT: if (wb_ready) nextState = scanLast ? DONE : SCAN;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            scanCnt   <= '0;
            flushMode <= 1'b0;
        end else begin
            state <= nextState;
            if ((state == IDLE) && flush_req) begin
                flushMode <= flush_wb;
                scanCnt   <= '0;
            end else if (clearEntry && !scanLast) begin
                scanCnt <= scanCnt + CNT_W'(1);
            end
        end
    end

    // NOTE: the status array is reset on purpose: stale valid bits after reset would fake cache hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                validMem[s] <= '0;
                dirtyMem[s] <= '0;
            end
        end else if (writeEn) begin
            for (int w = 0; w < WAYS; w++) begin
                if (way_sel[w]) begin
                    validMem[index][w] <= valid_in;
                    dirtyMem[index][w] <= valid_in & dirty_in;
                end
            end
        end else if (clearEntry) begin
            validMem[scanSet][scanWay] <= 1'b0;
            dirtyMem[scanSet][scanWay] <= 1'b0;
        end
    end

    assign valid_out  = validMem[index];
    assign dirty_out  = dirtyMem[index];

    assign flush_busy = (state != IDLE);
    assign flush_done = (state == DONE);
    assign wb_valid   = (state == WB_WAIT);
    assign wb_index   = scanSet;
    assign wb_way     = scanWay;

endmodule
